// File: rtl/sprite_renderer_param.sv
// rtl/sprite_renderer_param.sv - parametrised per-scanline sprite row fetch and 1-bit pixel serialiser
module sprite_renderer_param #(
    parameter int ROM_W  = 8,
    parameter int ROWS   = 16,
    parameter int MIRROR = 1,
    parameter int XSCALE = 1,
    localparam int AW    = $clog2(ROWS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             vstart_i,
    input  logic             load_i,
    input  logic             hstart_i,
    input  logic             hflip_i,
    input  logic             vflip_i,
    output logic [AW-1:0]    rom_addr_o,
    input  logic [ROM_W-1:0] rom_bits_i,
    output logic             gfx_o,
    output logic             in_progress_o,
    output logic             done_o
);

    localparam int SPR_W = (MIRROR != 0) ? 2 * ROM_W : ROM_W;
    localparam int XW    = $clog2(SPR_W);
    localparam int IW    = $clog2(ROM_W);
    localparam int SW    = (XSCALE > 1) ? $clog2(XSCALE) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(SPR_W - 1);
    localparam logic [SW-1:0] S_LAST = SW'(XSCALE - 1);
    localparam logic [AW-1:0] Y_LAST = AW'(ROWS - 1);

    localparam logic [2:0] S_WAIT_VSTART = 3'd0;
    localparam logic [2:0] S_WAIT_LOAD   = 3'd1;
    localparam logic [2:0] S_SETUP       = 3'd2;
    localparam logic [2:0] S_FETCH       = 3'd3;
    localparam logic [2:0] S_WAIT_HSTART = 3'd4;
    localparam logic [2:0] S_DRAW        = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    ycount_q, ycount_d;
    logic [XW-1:0]    xcount_q, xcount_d;
    logic [SW-1:0]    subcnt_q, subcnt_d;
    logic [ROM_W-1:0] outbits_q, outbits_d;
    logic             hflip_q, hflip_d;
    logic             vflip_q, vflip_d;
    logic [AW-1:0]    rom_addr_q, rom_addr_d;
    logic             gfx_q, gfx_d;
    logic             done_q, done_d;

    logic [XW-1:0]    xp;
    logic [XW-1:0]    xm;
    logic             pix;

    // Screen column -> ROM bit: optional horizontal flip, then fold the right half back onto the ROM row.
    always_comb begin
        xp = hflip_q ? (X_LAST - xcount_q) : xcount_q;
        if (MIRROR != 0 && xp >= XW'(ROM_W)) begin
            xm = XW'(2 * ROM_W - 1) - xp;
        end else begin
            xm = xp;
        end
        pix = outbits_q[xm[IW-1:0]];
    end

    always_comb begin
        state_d    = state_q;
        ycount_d   = ycount_q;
        xcount_d   = xcount_q;
        subcnt_d   = subcnt_q;
        outbits_d  = outbits_q;
        hflip_d    = hflip_q;
        vflip_d    = vflip_q;
        rom_addr_d = rom_addr_q;
        gfx_d      = gfx_q;
        done_d     = 1'b0;
        case (state_q)
            S_WAIT_VSTART: begin
                ycount_d = '0;
                gfx_d    = 1'b0;
                if (vstart_i) begin
                    hflip_d = hflip_i;
                    vflip_d = vflip_i;
                    state_d = S_WAIT_LOAD;
                end
            end
            S_WAIT_LOAD: begin
                xcount_d = '0;
                subcnt_d = '0;
                gfx_d    = 1'b0;
                if (load_i) state_d = S_SETUP;
            end
            S_SETUP: begin
                gfx_d      = 1'b0;
                rom_addr_d = vflip_q ? (Y_LAST - ycount_q) : ycount_q;
                state_d    = S_FETCH;
            end
            S_FETCH: begin
                gfx_d     = 1'b0;
                outbits_d = rom_bits_i;
                state_d   = S_WAIT_HSTART;
            end
            S_WAIT_HSTART: begin
                gfx_d = 1'b0;
                if (hstart_i) state_d = S_DRAW;
            end
            S_DRAW: begin
                gfx_d = pix;
                if (subcnt_q == S_LAST) begin
                    subcnt_d = '0;
                    if (xcount_q == X_LAST) begin
                        // End of row: the last row finishes the sprite, otherwise wait for the next hsync.
                        if (ycount_q == Y_LAST) begin
                            state_d = S_WAIT_VSTART;
                            done_d  = 1'b1;
                        end else begin
                            ycount_d = ycount_q + 1'b1;
                            state_d  = S_WAIT_LOAD;
                        end
                    end else begin
                        xcount_d = xcount_q + 1'b1;
                    end
                end else begin
                    subcnt_d = subcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT_VSTART;
                gfx_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_WAIT_VSTART;
            ycount_q   <= '0;
            xcount_q   <= '0;
            subcnt_q   <= '0;
            outbits_q  <= '0;
            hflip_q    <= 1'b0;
            vflip_q    <= 1'b0;
            rom_addr_q <= '0;
            gfx_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ycount_q   <= ycount_d;
            xcount_q   <= xcount_d;
            subcnt_q   <= subcnt_d;
            outbits_q  <= outbits_d;
            hflip_q    <= hflip_d;
            vflip_q    <= vflip_d;
            rom_addr_q <= rom_addr_d;
            gfx_q      <= gfx_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr_o    = rom_addr_q;
    assign gfx_o         = gfx_q;
    assign done_o        = done_q;
    assign in_progress_o = (state_q != S_WAIT_VSTART);

endmodule

// File: tb/tb_sprite_renderer_param.sv
// tb/tb_sprite_renderer_param.sv - randomized self-checking bench, mirrored x1 and unmirrored x4 instances
module tb_sprite_renderer_param;

    typedef bit bitq_t [$];

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       rst_n, vstart, load, hstart, hflip, vflip;
    logic [7:0] rom [16];
    logic [3:0] addr_a, addr_b;
    logic [7:0] bits_a, bits_b;
    logic       gfx_a, gfx_b, ip_a, ip_b, done_a, done_b;

    int errors = 0;
    int checks = 0;
    int dcnt_a = 0;
    int dcnt_b = 0;

    assign bits_a = rom[addr_a];
    assign bits_b = rom[addr_b];

    always @(posedge clk_i) begin
        if (done_a === 1'b1) dcnt_a <= dcnt_a + 1;
        if (done_b === 1'b1) dcnt_b <= dcnt_b + 1;
    end

    sprite_renderer_param #(.ROM_W(8), .ROWS(16), .MIRROR(1), .XSCALE(1)) u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_n), .vstart_i(vstart), .load_i(load), .hstart_i(hstart),
        .hflip_i(hflip), .vflip_i(vflip), .rom_addr_o(addr_a), .rom_bits_i(bits_a),
        .gfx_o(gfx_a), .in_progress_o(ip_a), .done_o(done_a)
    );

    sprite_renderer_param #(.ROM_W(8), .ROWS(16), .MIRROR(0), .XSCALE(4)) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_n), .vstart_i(vstart), .load_i(load), .hstart_i(hstart),
        .hflip_i(hflip), .vflip_i(vflip), .rom_addr_o(addr_b), .rom_bits_i(bits_b),
        .gfx_o(gfx_b), .in_progress_o(ip_b), .done_o(done_b)
    );

    // Left-to-right picture of one scanline: ROM bit0 is the leftmost pixel.
    function automatic bitq_t row_stream(logic [7:0] bits, int mirror, int xscale, bit hf);
        bitq_t px;
        bitq_t rev;
        bitq_t out;
        for (int i = 0; i < 8; i++) px.push_back(bits[i]);
        if (mirror != 0) for (int i = 7; i >= 0; i--) px.push_back(bits[i]);
        if (hf) begin
            foreach (px[i]) rev.push_front(px[i]);
            px = rev;
        end
        foreach (px[i]) for (int k = 0; k < xscale; k++) out.push_back(px[i]);
        return out;
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic fill_rom_random;
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    endtask

    task automatic run_frame(input bit hf, input bit vf, input bit inject, input int reset_row, input string tag);
        bitq_t ea;
        bitq_t eb;
        int    da0, db0, row;
        bit    exp_ga, exp_gb, exp_da, exp_db;
        da0 = dcnt_a;
        db0 = dcnt_b;
        tick;
        vstart = 1'b1; hflip = hf; vflip = vf; hstart = inject;
        tick;
        vstart = 1'b0; hstart = 1'b0; hflip = 1'($urandom); vflip = 1'($urandom);
        checks++;
        if (ip_a !== 1'b1 || ip_b !== 1'b1) begin
            errors++;
            $display("FAIL %s in_progress after vstart got %b/%b exp 1/1", tag, ip_a, ip_b);
        end
        for (int r = 0; r < 16; r++) begin
            row = vf ? 15 - r : r;
            ea  = row_stream(rom[row], 1, 1, hf);
            eb  = row_stream(rom[row], 0, 4, hf);
            repeat ($urandom_range(0, 3)) tick;
            if (inject && r == 3) begin
                hstart = 1'b1;
                tick;
                hstart = 1'b0;
            end
            load = 1'b1;
            tick;
            load = 1'b0;
            tick;
            checks++;
            if (addr_a !== 4'(row) || addr_b !== 4'(row)) begin
                errors++;
                $display("FAIL %s rom_addr line%0d got %0d/%0d exp %0d", tag, r, addr_a, addr_b, row);
            end
            tick;
            repeat ($urandom_range(0, 3)) tick;
            hstart = 1'b1;
            tick;
            hstart = 1'b0;
            for (int s = 2; s <= 34; s++) begin
                tick;
                if (inject && r == 3 && s == 5) begin
                    vstart = 1'b1; load = 1'b1; hflip = ~hf; vflip = ~vf;
                end else begin
                    vstart = 1'b0; load = 1'b0;
                end
                if (reset_row == r && s == 6) begin
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    if (gfx_a !== 1'b0 || gfx_b !== 1'b0 || addr_a !== 4'd0 || addr_b !== 4'd0 ||
                        ip_a !== 1'b0 || ip_b !== 1'b0) begin
                        errors++;
                        $display("FAIL %s async reset got gfx=%b/%b addr=%0d/%0d ip=%b/%b exp all 0",
                                 tag, gfx_a, gfx_b, addr_a, addr_b, ip_a, ip_b);
                    end
                    return;
                end
                exp_ga = (s - 2 < ea.size()) ? ea[s - 2] : 1'b0;
                exp_gb = (s - 2 < eb.size()) ? eb[s - 2] : 1'b0;
                exp_da = (r == 15 && s == ea.size() + 1);
                exp_db = (r == 15 && s == eb.size() + 1);
                checks++;
                if (gfx_a !== exp_ga || done_a !== exp_da) begin
                    errors++;
                    $display("FAIL %s dut_a line%0d s%0d gfx/done got %b%b exp %b%b", tag, r, s, gfx_a, done_a, exp_ga, exp_da);
                end
                checks++;
                if (gfx_b !== exp_gb || done_b !== exp_db) begin
                    errors++;
                    $display("FAIL %s dut_b line%0d s%0d gfx/done got %b%b exp %b%b", tag, r, s, gfx_b, done_b, exp_gb, exp_db);
                end
            end
        end
        checks++;
        if (ip_a !== 1'b0 || ip_b !== 1'b0) begin
            errors++;
            $display("FAIL %s in_progress after frame got %b/%b exp 0/0", tag, ip_a, ip_b);
        end
        checks++;
        if (dcnt_a - da0 != 1 || dcnt_b - db0 != 1) begin
            errors++;
            $display("FAIL %s done pulse count got %0d/%0d exp 1/1", tag, dcnt_a - da0, dcnt_b - db0);
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (3) tick;
        checks++;
        if (gfx_a !== 1'b0 || gfx_b !== 1'b0 || addr_a !== 4'd0 || addr_b !== 4'd0 ||
            done_a !== 1'b0 || done_b !== 1'b0 || ip_a !== 1'b0 || ip_b !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs got gfx=%b/%b addr=%0d/%0d done=%b/%b ip=%b/%b exp all 0",
                     gfx_a, gfx_b, addr_a, addr_b, done_a, done_b, ip_a, ip_b);
        end
        rst_n = 1'b1;
        load = 1'b1; hstart = 1'b1;
        repeat (4) tick;
        load = 1'b0; hstart = 1'b0;
        checks++;
        if (ip_a !== 1'b0 || ip_b !== 1'b0 || gfx_a !== 1'b0 || gfx_b !== 1'b0) begin
            errors++;
            $display("FAIL idle without vstart got ip=%b/%b gfx=%b/%b exp 0", ip_a, ip_b, gfx_a, gfx_b);
        end
    endtask

    task automatic test_mirror_row;
        fill_rom_random();
        rom[0] = 8'b0000_0011;
        run_frame(1'b0, 1'b0, 1'b0, -1, "mirror");
    endtask

    task automatic test_hflip;
        fill_rom_random();
        rom[0] = 8'b0000_0001;
        run_frame(1'b1, 1'b0, 1'b0, -1, "hflip");
    endtask

    task automatic test_vflip;
        for (int i = 0; i < 16; i++) rom[i] = 8'(i);
        run_frame(1'b0, 1'b1, 1'b0, -1, "vflip");
    endtask

    task automatic test_xscale;
        fill_rom_random();
        rom[0] = 8'b1000_0001;
        run_frame(1'b0, 1'b0, 1'b0, -1, "xscale");
    endtask

    task automatic test_reset_mid_draw;
        fill_rom_random();
        rom[5] = 8'hFF;
        run_frame(1'b0, 1'b0, 1'b0, 5, "abort");
        tick;
        tick;
        rst_n = 1'b1;
        fill_rom_random();
        run_frame(1'($urandom), 1'($urandom), 1'b0, -1, "restart");
    endtask

    task automatic test_ignored_events;
        fill_rom_random();
        run_frame(1'b1, 1'b0, 1'b1, -1, "ignored");
    endtask

    task automatic test_random_frames;
        for (int f = 0; f < 4; f++) begin
            fill_rom_random();
            run_frame(1'($urandom), 1'($urandom), 1'($urandom), -1, "random");
        end
    endtask

    initial begin
        rst_n = 1'b1; vstart = 1'b0; load = 1'b0; hstart = 1'b0; hflip = 1'b0; vflip = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        test_reset();
        test_mirror_row();
        test_hflip();
        test_vflip();
        test_xscale();
        test_reset_mid_draw();
        test_ignored_events();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
